// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the hit-the-LED game sequencer: session states and display widths.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned SCORE_MAX = 255;
    localparam int unsigned DIFF_W    = 3;

endpackage

// File: rtl/game_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/game_ctrl.sv
// Session sequencer: idle -> ready countdown -> play -> game over, with score, lives and
// difficulty tracking from the hit/miss pulses of the judging logic.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned HITS_PER_LEVEL = 8,
    parameter int unsigned MAX_DIFF       = 7,
    parameter int unsigned READY_CYCLES   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hit,
    input  logic              miss,
    output logic              enable,
    output logic [DIFF_W-1:0] difficulty,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]        lives,
    output logic [1:0]        state,
    output logic              game_over
);

    localparam int unsigned STREAK_W = $clog2(HITS_PER_LEVEL + 1);
    localparam int unsigned CNT_W    = $clog2(READY_CYCLES + 1);

    localparam logic [CNT_W-1:0]    READY_LAST = CNT_W'(READY_CYCLES - 1);
    localparam logic [STREAK_W-1:0] HITS_LAST  = STREAK_W'(HITS_PER_LEVEL - 1);
    localparam logic [1:0]          LIVES_INIT = 2'(LIVES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [1:0]          lives_q, lives_d;
    logic                start_q;
    logic                enable_q, game_over_q;

    logic start_rise;
    logic game_clr;
    logic score_inc;
    logic diff_inc;

    assign start_rise = start & ~start_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        lives_d   = lives_q;
        game_clr  = 1'b0;
        score_inc = 1'b0;
        diff_inc  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_READY;
                    cnt_d    = '0;
                    streak_d = '0;
                    lives_d  = LIVES_INIT;
                    game_clr = 1'b1;
                end
            end
            ST_READY: begin
                if (cnt_q == READY_LAST) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PLAY: begin
                // A miss in the same cycle as a hit discards the hit entirely.
                if (miss) begin
                    lives_d  = lives_q - 1'b1;
                    streak_d = '0;
                    if (lives_q == 2'd1) begin
                        state_d = ST_OVER;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                    if (streak_q == HITS_LAST) begin
                        streak_d = '0;
                        diff_inc = 1'b1;
                    end else begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            lives_q     <= '0;
            start_q     <= 1'b0;
            enable_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            lives_q     <= lives_d;
            start_q     <= start;
            enable_q    <= (state_d == ST_PLAY);
            game_over_q <= (state_d == ST_OVER);
        end
    end

    sat_counter #(
        .WIDTH (SCORE_W),
        .MAX   (SCORE_MAX)
    ) u_score (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (game_clr),
        .inc_i   (score_inc),
        .count_o (score)
    );

    sat_counter #(
        .WIDTH (DIFF_W),
        .MAX   (MAX_DIFF)
    ) u_difficulty (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (game_clr),
        .inc_i   (diff_inc),
        .count_o (difficulty)
    );

    assign enable    = enable_q;
    assign game_over = game_over_q;
    assign lives     = lives_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a behavioural game model queues expected outputs per
// driven cycle, and each queued entry is compared after the following clock edge.
module tb_game_ctrl;

    localparam int unsigned R_CYC = 4;
    localparam int unsigned N_LIV = 3;
    localparam int unsigned HPL   = 8;
    localparam int unsigned MAXD  = 7;

    typedef struct {
        int unsigned st;
        int unsigned en;
        int unsigned diff;
        int unsigned score;
        int unsigned lives;
        int unsigned go;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start, hit, miss;
    logic       enable, game_over;
    logic [2:0] difficulty;
    logic [7:0] score;
    logic [1:0] lives, state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        exp_q[$];

    // reference model state
    int unsigned m_st, m_score, m_lives, m_diff, m_streak, m_cnt;
    logic        m_start_q;

    game_ctrl #(
        .LIVES          (N_LIV),
        .HITS_PER_LEVEL (HPL),
        .MAX_DIFF       (MAXD),
        .READY_CYCLES   (R_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hit        (hit),
        .miss       (miss),
        .enable     (enable),
        .difficulty (difficulty),
        .score      (score),
        .lives      (lives),
        .state      (state),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_score = 0; m_lives = 0; m_diff = 0; m_streak = 0; m_cnt = 0;
        m_start_q = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic h, input logic m);
        logic rise;
        exp_t e;
        rise = s & ~m_start_q;
        case (m_st)
            0, 3: if (rise) begin
                m_st = 1; m_score = 0; m_lives = N_LIV; m_diff = 0; m_streak = 0; m_cnt = 0;
            end
            1: begin
                if (m_cnt == R_CYC - 1) m_st = 2;
                else m_cnt++;
            end
            2: begin
                if (m) begin
                    if (m_lives == 1) m_st = 3;
                    m_lives--;
                    m_streak = 0;
                end else if (h) begin
                    if (m_score < 255) m_score++;
                    m_streak++;
                    if (m_streak == HPL) begin
                        m_streak = 0;
                        if (m_diff < MAXD) m_diff++;
                    end
                end
            end
            default: ;
        endcase
        m_start_q = s;
        e.st = m_st; e.en = (m_st == 2) ? 1 : 0; e.go = (m_st == 3) ? 1 : 0;
        e.diff = m_diff; e.score = m_score; e.lives = m_lives;
        exp_q.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_queue_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_eq("sb_state", state, e.st);
        check_eq("sb_enable", enable, e.en);
        check_eq("sb_difficulty", difficulty, e.diff);
        check_eq("sb_score", score, e.score);
        check_eq("sb_lives", lives, e.lives);
        check_eq("sb_game_over", game_over, e.go);
    endtask

    // drive one cycle of inputs, queue the model's expectation, compare after the edge
    task automatic step(input logic s, input logic h, input logic m);
        start = s; hit = h; miss = m;
        model_step(s, h, m);
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    task automatic enter_play(input string tag);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_eq({tag, "_ready"}, state, 1);
        check_eq({tag, "_ready_score"}, score, 0);
        check_eq({tag, "_ready_lives"}, lives, 3);
        for (int i = 0; i < int'(R_CYC) - 1; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check_eq({tag, "_ready_hold"}, state, 1);
        end
        check_eq({tag, "_ready_no_hit"}, score, 0);
        step(1'b1, 1'b0, 1'b0);
        check_eq({tag, "_play"}, state, 2);
        check_eq({tag, "_play_en"}, enable, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hit = 1'b0; miss = 1'b0;
        model_reset();
        #12;
        check_eq("rst_state", state, 0);
        check_eq("rst_enable", enable, 0);
        check_eq("rst_score", score, 0);
        check_eq("rst_lives", lives, 0);
        check_eq("rst_diff", difficulty, 0);
        check_eq("rst_game_over", game_over, 0);
        rst = 1'b0;

        // game 1: countdown, level-ups, streak reset by miss, saturation, game over
        enter_play("g1");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("lvl_before_8th", difficulty, 0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("lvl_after_8th", difficulty, 1);
        check_eq("score_8", score, 8);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_eq("hitmiss_lives", lives, 2);
        check_eq("hitmiss_score", score, 13);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("streak_cleared", difficulty, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("streak_8_again", difficulty, 2);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("diff_max", difficulty, 7);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("diff_held_max", difficulty, 7);
        for (int i = 0; i < 186; i++) step(1'b1, 1'b1, 1'b0);
        check_eq("score_255", score, 255);
        step(1'b1, 1'b1, 1'b0);
        check_eq("score_sat", score, 255);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_eq("g1_over_state", state, 3);
        check_eq("g1_over_flag", game_over, 1);
        check_eq("g1_over_score_held", score, 255);

        // game 2: restart from OVER, three misses end the game
        enter_play("g2");
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_eq("miss1_lives", lives, 2);
        step(1'b1, 1'b0, 1'b1);
        check_eq("miss2_lives", lives, 1);
        step(1'b1, 1'b0, 1'b1);
        check_eq("miss3_lives", lives, 0);
        check_eq("miss3_state", state, 3);
        check_eq("miss3_enable", enable, 0);
        check_eq("miss3_game_over", game_over, 1);
        step(1'b1, 1'b1, 1'b0);
        check_eq("over_hit_ignored", score, 2);

        // game 3: asynchronous reset in the middle of play
        enter_play("g3");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("pre_reset_score", score, 5);
        hit = 1'b0; start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_state", state, 0);
        check_eq("async_rst_enable", enable, 0);
        check_eq("async_rst_score", score, 0);
        model_reset();
        #3 rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("post_rst_idle", state, 0);
        check_eq("post_rst_no_count", score, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
